// File: rtl/stage_evaluator.sv
// Cascade-stage evaluator: walks one stage record in the stage ROM, launches
// feature_calculator per feature, and accumulates saturating weak-classifier votes.
module stage_evaluator #(
    parameter int DATA_WIDTH       = 32,
    parameter int FIXED_POINT_FRAC = 16,
    parameter int ADDR_WIDTH       = 17
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        stage_addr,
    input  logic [7:0]                   window_x,
    input  logic [7:0]                   window_y,
    input  logic [7:0]                   window_scale,
    output logic [ADDR_WIDTH-1:0]        stage_rom_addr,
    input  logic [DATA_WIDTH-1:0]        stage_rom_data,
    output logic                         fc_start,
    output logic [11:0]                  fc_feature_index,
    output logic [7:0]                   fc_window_x,
    output logic [7:0]                   fc_window_y,
    output logic [7:0]                   fc_window_scale,
    input  logic signed [DATA_WIDTH-1:0] fc_feature_value,
    input  logic                         fc_done,
    output logic                         busy,
    output logic                         done,
    output logic                         stage_pass,
    output logic signed [DATA_WIDTH-1:0] stage_sum
);
    // Q-format is informational only; all arithmetic treats words as raw signed integers.
    if (FIXED_POINT_FRAC >= DATA_WIDTH) begin : g_frac_out_of_range
    end

    localparam logic signed [DATA_WIDTH-1:0] SUM_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SUM_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_THR, S_NODE, S_WAIT_FC, S_DONE} state_t;

    state_t                       state, state_nxt;
    logic [1:0]                   step;
    logic [7:0]                   num_feat, feat_cnt;
    logic signed [DATA_WIDTH-1:0] stage_thr, node_thr, left_val, right_val;
    logic signed [DATA_WIDTH-1:0] vote, sum_sat;
    logic signed [DATA_WIDTH:0]   sum_ext;
    logic                         last_feat;

    assign last_feat = (feat_cnt == num_feat - 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        vote      = (fc_feature_value < node_thr) ? left_val : right_val;
        sum_ext   = {stage_sum[DATA_WIDTH-1], stage_sum} + {vote[DATA_WIDTH-1], vote};
        sum_sat   = sum_ext[DATA_WIDTH-1:0];
        // Overflow shows up as disagreement between the extra sign bit and the result sign.
        if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1])
            sum_sat = sum_ext[DATA_WIDTH] ? SUM_MIN : SUM_MAX;
        case (state)
            S_IDLE:    if (start) state_nxt = S_HDR;
            S_HDR:     state_nxt = S_THR;
            S_THR:     state_nxt = (num_feat == 8'd0) ? S_DONE : S_NODE;
            S_NODE:    if (step == 2'd3) state_nxt = S_WAIT_FC;
            S_WAIT_FC: if (fc_done) state_nxt = last_feat ? S_DONE : S_NODE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_rom_addr   <= '0;
            fc_start         <= 1'b0;
            fc_feature_index <= '0;
            fc_window_x      <= '0;
            fc_window_y      <= '0;
            fc_window_scale  <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            stage_pass       <= 1'b0;
            stage_sum        <= '0;
            step             <= '0;
            num_feat         <= '0;
            feat_cnt         <= '0;
            stage_thr        <= '0;
            node_thr         <= '0;
            left_val         <= '0;
            right_val        <= '0;
        end else begin
            fc_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    fc_window_x     <= window_x;
                    fc_window_y     <= window_y;
                    fc_window_scale <= window_scale;
                    stage_sum       <= '0;
                    stage_pass      <= 1'b0;
                    feat_cnt        <= '0;
                    stage_rom_addr  <= stage_addr;
                    busy            <= 1'b1;
                end
                S_HDR: begin
                    num_feat       <= stage_rom_data[7:0];
                    stage_rom_addr <= stage_rom_addr + ADDR_WIDTH'(1);
                end
                S_THR: begin
                    stage_thr      <= stage_rom_data;
                    stage_rom_addr <= stage_rom_addr + ADDR_WIDTH'(1);
                    step           <= '0;
                end
                S_NODE: begin
                    case (step)
                        2'd0: fc_feature_index <= stage_rom_data[11:0];
                        2'd1: node_thr         <= stage_rom_data;
                        2'd2: left_val         <= stage_rom_data;
                        default: begin
                            right_val <= stage_rom_data;
                            fc_start  <= 1'b1;
                        end
                    endcase
                    step           <= step + 2'd1;
                    stage_rom_addr <= stage_rom_addr + ADDR_WIDTH'(1);
                end
                S_WAIT_FC: if (fc_done) begin
                    stage_sum <= sum_sat;
                    feat_cnt  <= feat_cnt + 8'd1;
                end
                S_DONE: begin
                    stage_pass <= (stage_sum >= stage_thr);
                    done       <= 1'b1;
                    busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
